// File: rtl/generador_cuenta_vga.sv
// generador_cuenta_vga: VGA timing generator.
// Divides the system clock down to a pixel tick and runs the horizontal and
// vertical pixel counters. It also produces registered hsync/vsync/video_on
// signals and a one-clock end-of-frame pulse.
//
// Ports:
//   clk        in   system clock; all logic runs on its rising edge
//   reset      in   synchronous, active-high; takes priority over enable
//   enable     in   1 = run, 0 = freeze the divider, counters and decodes
//   cuenta     out  horizontal pixel count, 0..H_TOTAL-1
//   cuenta_v   out  vertical line count, 0..V_TOTAL-1
//   pixel_tick out  one-clock pulse per pixel period
//   hsync      out  horizontal sync, active low
//   vsync      out  vertical sync, active low
//   video_on   out  high inside the visible region
//   fin_cuadro out  one-clock pulse on the last pixel of a frame
module generador_cuenta_vga #(
  parameter int unsigned CLK_DIV   = 4,
  parameter int unsigned H_VISIBLE = 640,
  parameter int unsigned H_FRONT   = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BACK    = 48,
  parameter int unsigned V_VISIBLE = 480,
  parameter int unsigned V_FRONT   = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BACK    = 33
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  output logic [9:0] cuenta,
  output logic [9:0] cuenta_v,
  output logic       pixel_tick,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic       fin_cuadro
);

  localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
  localparam logic [9:0] HS_FIRST = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_LAST  = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_LAST  = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);

  logic [DIV_W-1:0] div_q, div_d;
  logic [9:0]       h_q, h_d;
  logic [9:0]       v_q, v_d;
  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
  logic             video_q, video_d;
  logic             tick;

  assign tick = enable & ~reset & (div_q == DIV_LAST);

  always_comb begin
    div_d = div_q;
    h_d   = h_q;
    v_d   = v_q;
    if (enable) begin
      div_d = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
    end
    if (tick) begin
      if (h_q == H_LAST) begin
        h_d = '0;
        v_d = (v_q == V_LAST) ? '0 : v_q + 10'd1;
      end else begin
        h_d = h_q + 10'd1;
      end
    end
    // Decoded from the next-state counts so the registered syncs line up
    // with the counters on the same cycle.
    hsync_d = ~((h_d >= HS_FIRST) && (h_d <= HS_LAST));
    vsync_d = ~((v_d >= VS_FIRST) && (v_d <= VS_LAST));
    video_d = (h_d < H_VIS) && (v_d < V_VIS);
  end

  // When enable=0 the next-state counts equal the held counts, so the decode
  // registers reload identical values, except on the first edge after reset,
  // where video_on rises because the counts sit at (0,0).
  always_ff @(posedge clk) begin
    if (reset) begin
      div_q   <= '0;
      h_q     <= '0;
      v_q     <= '0;
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
      video_q <= 1'b0;
    end else begin
      div_q   <= div_d;
      h_q     <= h_d;
      v_q     <= v_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      video_q <= video_d;
    end
  end

  assign cuenta     = h_q;
  assign cuenta_v   = v_q;
  assign pixel_tick = tick;
  assign hsync      = hsync_q;
  assign vsync      = vsync_q;
  assign video_on   = video_q;
  assign fin_cuadro = tick & (h_q == H_LAST) & (v_q == V_LAST);

endmodule

// File: tb/tb_generador_cuenta_vga.sv
// Testbench for generador_cuenta_vga.
// Instance A uses the default 640x480 timing with CLK_DIV=4.
// Instance B uses a tiny 15x11 geometry with CLK_DIV=1, so whole frames fit
// in a short run.
// The reference model keeps only the count of enabled pixel clocks since
// reset and derives every expected output from it arithmetically.
module tb_generador_cuenta_vga;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic ra, ea, rb, eb;
  logic [9:0] ca, cva, cb, cvb;
  logic pta, hsa, vsa, voa, fca;
  logic ptb, hsb, vsb, vob, fcb;

  int checks = 0;
  int errors = 0;

  longint na = 0, nb = 0;   // enabled, non-reset edges since the last reset
  bit     rla = 1, rlb = 1; // most recent edge was a reset edge

  generador_cuenta_vga #(
    .CLK_DIV(4), .H_VISIBLE(640), .H_FRONT(16), .H_SYNC(96), .H_BACK(48),
    .V_VISIBLE(480), .V_FRONT(10), .V_SYNC(2), .V_BACK(33)
  ) dut_a (
    .clk(clk), .reset(ra), .enable(ea), .cuenta(ca), .cuenta_v(cva),
    .pixel_tick(pta), .hsync(hsa), .vsync(vsa), .video_on(voa), .fin_cuadro(fca)
  );

  generador_cuenta_vga #(
    .CLK_DIV(1), .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_VISIBLE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(2)
  ) dut_b (
    .clk(clk), .reset(rb), .enable(eb), .cuenta(cb), .cuenta_v(cvb),
    .pixel_tick(ptb), .hsync(hsb), .vsync(vsb), .video_on(vob), .fin_cuadro(fcb)
  );

  task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s at t=%0t observed %0d expected %0d", tag, $time, obs, exp);
    end
  endtask

  task automatic model_check(
    input string tag, input int d,
    input int hv, input int hf, input int hs, input int hb,
    input int vv, input int vf, input int vs, input int vb,
    input longint n, input bit rl, input logic r, input logic e,
    input logic [9:0] c, input logic [9:0] cv,
    input logic pt, input logic hso, input logic vso, input logic vo, input logic fc);
    longint ht, vt, p, h, v;
    bit et, ef, ehs, evs, evo;
    ht  = hv + hf + hs + hb;
    vt  = vv + vf + vs + vb;
    p   = n / d;
    h   = p % ht;
    v   = (p / ht) % vt;
    et  = e && !r && ((n % d) == d - 1);
    ef  = et && ((p % (ht * vt)) == ht * vt - 1);
    ehs = rl ? 1'b1 : !(h >= hv + hf && h < hv + hf + hs);
    evs = rl ? 1'b1 : !(v >= vv + vf && v < vv + vf + vs);
    evo = rl ? 1'b0 : (h < hv && v < vv);
    chk({tag, ".cuenta"},     c,   10'(h));
    chk({tag, ".cuenta_v"},   cv,  10'(v));
    chk({tag, ".pixel_tick"}, {9'd0, pt},  {9'd0, et});
    chk({tag, ".hsync"},      {9'd0, hso}, {9'd0, ehs});
    chk({tag, ".vsync"},      {9'd0, vso}, {9'd0, evs});
    chk({tag, ".video_on"},   {9'd0, vo},  {9'd0, evo});
    chk({tag, ".fin_cuadro"}, {9'd0, fc},  {9'd0, ef});
  endtask

  // Drive one clock cycle: apply inputs, check mid-cycle, then advance the model.
  task automatic step(input logic r_a, input logic e_a, input logic r_b, input logic e_b);
    ra = r_a; ea = e_a; rb = r_b; eb = e_b;
    #2;
    model_check("A", 4, 640, 16, 96, 48, 480, 10, 2, 33, na, rla, ra, ea,
                ca, cva, pta, hsa, vsa, voa, fca);
    model_check("B", 1, 8, 2, 3, 2, 6, 1, 2, 2, nb, rlb, rb, eb,
                cb, cvb, ptb, hsb, vsb, vob, fcb);
    @(posedge clk);
    if (ra) begin na = 0; rla = 1; end
    else begin if (ea) na++; rla = 0; end
    if (rb) begin nb = 0; rlb = 1; end
    else begin if (eb) nb++; rlb = 0; end
    #1;
  endtask

  initial begin
    ra = 1'b1; ea = 1'b0; rb = 1'b1; eb = 1'b1;
    @(posedge clk);
    #1;
    // Reset held, with enable both high and low.
    step(1, 1, 1, 1);
    step(1, 0, 1, 0);
    // First pixels, the hsync window, a full line, and several small frames.
    for (int i = 0; i < 3300; i++) step(0, 1, 0, 1);
    // Freeze at divider=2, cuenta=100 for 10 clocks, then resume.
    step(1, 0, 1, 0);
    while (na < 402) step(0, 1, 0, 1);
    for (int i = 0; i < 10; i++) step(0, 0, 0, 0);
    for (int i = 0; i < 10; i++) step(0, 1, 0, 1);
    // Reset at cuenta=700 (hsync low) with enable low, then release.
    while (na < 2800) step(0, 1, 0, 1);
    step(1, 0, 1, 0);
    step(0, 0, 0, 0);
    step(0, 1, 0, 1);
    // Reset at cuenta=700 again, this time with enable high.
    while (na < 2800) step(0, 1, 0, 1);
    step(1, 1, 1, 1);
    step(0, 1, 0, 1);
    // Randomized enable pattern with occasional resets on instance B.
    for (int i = 0; i < 4000; i++)
      step(1'b0, ($urandom_range(3) != 0), ($urandom_range(63) == 0), ($urandom_range(3) != 0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
